// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage.
// Owns the fetch PC and runs the I-cache read handshake. Returned
// instructions are buffered with their PCs in a small FIFO that the decode
// side drains. A branch redirect (ld_br) flushes everything fetched but not
// yet issued, and fetch restarts at br_target.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   instr_read         I-cache read request, held until instr_mem_resp
//   instr_mem_address  I-cache read address (address of outstanding request)
//   instr_mem_rdata    I-cache read data, valid with instr_mem_resp
//   instr_mem_resp     I-cache one-cycle response strobe
//   ld_br, br_target   redirect strobe and target PC from ROB commit
//   deq                consumer takes the head entry
//   out_valid          FIFO non-empty
//   out_instr, out_pc  head entry instruction and PC
//   count              number of occupied FIFO entries
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         instr_read,
  output logic [31:0]                  instr_mem_address,
  input  logic [31:0]                  instr_mem_rdata,
  input  logic                         instr_mem_resp,
  input  logic                         ld_br,
  input  logic [31:0]                  br_target,
  input  logic                         deq,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e            state_q;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       req_addr_q;
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [PtrW-1:0]   head_q;
  logic [PtrW-1:0]   tail_q;
  logic [CntW-1:0]   count_q;

  logic              deq_ok;
  logic              enq;
  logic              flush;
  logic [CntW-1:0]   cnt_after_deq;
  logic              room_idle;
  logic              room_req;

  always_comb begin
    deq_ok        = deq && (count_q != '0);
    // Data returned in the same cycle as a redirect is wrong-path: drop it.
    enq           = (state_q == StReq) && instr_mem_resp && !ld_br;
    flush         = ld_br;
    cnt_after_deq = count_q - CntW'(deq_ok);
    // IDLE: a slot must be free after this cycle's deq to reserve one.
    room_idle     = cnt_after_deq < CntW'(DEPTH);
    // REQ: the response consumes one slot; another must remain for the next
    // back-to-back request.
    room_req      = cnt_after_deq < CntW'(DEPTH - 1);
  end

  // Fetch control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ld_br) begin
            fetch_pc_q <= br_target;
          end else if (room_idle) begin
            req_addr_q <= fetch_pc_q;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (ld_br) begin
            fetch_pc_q <= br_target;
            // The cache cannot abort, so an unanswered request is drained in DROP.
            state_q    <= instr_mem_resp ? StIdle : StDrop;
          end else if (instr_mem_resp) begin
            fetch_pc_q <= req_addr_q + 32'd4;
            if (room_req) begin
              req_addr_q <= req_addr_q + 32'd4;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDrop: begin
          if (ld_br) fetch_pc_q <= br_target;
          if (instr_mem_resp) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Instruction FIFO. Flush wins over any enqueue or dequeue in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        pc_mem_q[tail_q]    <= req_addr_q;
        instr_mem_q[tail_q] <= instr_mem_rdata;
        tail_q              <= tail_q + PtrW'(1);
      end
      if (deq_ok) head_q <= head_q + PtrW'(1);
      count_q <= count_q + CntW'(enq) - CntW'(deq_ok);
    end
  end

  assign instr_read        = (state_q != StIdle);
  assign instr_mem_address = req_addr_q;
  assign out_valid         = (count_q != '0);
  assign out_instr         = instr_mem_q[head_q];
  assign out_pc            = pc_mem_q[head_q];
  assign count             = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (DEPTH=4).
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic [31:0] instr_mem_rdata;
  logic        instr_mem_resp;
  logic        ld_br;
  logic [31:0] br_target;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h40000060)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_rdata   (instr_mem_rdata),
    .instr_mem_resp    (instr_mem_resp),
    .ld_br             (ld_br),
    .br_target         (br_target),
    .deq               (deq),
    .out_valid         (out_valid),
    .out_instr         (out_instr),
    .out_pc            (out_pc),
    .count             (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ld_br          = 1'b0;
    deq            = 1'b0;
    instr_mem_resp = 1'b0;
    instr_mem_rdata = '0;
    br_target      = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_br = 1'b0; deq = 1'b0; instr_mem_resp = 1'b0;
    instr_mem_rdata = '0; br_target = '0;
    #3;
    vectors++;
    if (instr_read !== 1'b0) begin
      miscompares++; $display("FAIL reset_read: got %b want 0", instr_read);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (count !== 3'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d want 0", count);
    end
    vectors++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0 || instr_mem_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got pc=%h instr=%h addr=%h want all 0",
               out_pc, out_instr, instr_mem_address);
    end
  endtask

  task automatic test_stream();
    logic [31:0] d [3];
    d[0] = 32'h000170b3; d[1] = 32'h0001f133; d[2] = 32'h000271b3;
    do_reset();
    deq = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000060 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_req%0d: got read=%b addr=%h want 1 %h", i, instr_read,
                 instr_mem_address, 32'h40000060 + 32'(4 * i));
      end
      tick();
      vectors++;
      if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000060 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_hold%0d: got read=%b addr=%h", i, instr_read, instr_mem_address);
      end
      instr_mem_resp = 1'b1; instr_mem_rdata = d[i];
      tick();
      instr_mem_resp = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h40000060 + 32'(4 * i) || out_instr !== d[i]) begin
        miscompares++;
        $display("FAIL stream_out%0d: got v=%b pc=%h instr=%h want 1 %h %h", i, out_valid,
                 out_pc, out_instr, 32'h40000060 + 32'(4 * i), d[i]);
      end
    end
    deq = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000060 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL full_req%0d: got read=%b addr=%h", i, instr_read, instr_mem_address);
      end
      instr_mem_resp = 1'b1; instr_mem_rdata = 32'(i + 1);
      tick();
    end
    instr_mem_resp = 1'b0;
    vectors++;
    if (instr_read !== 1'b0 || count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_stop: got read=%b count=%0d want 0 4", instr_read, count);
    end
    vectors++;
    if (out_pc !== 32'h40000060 || out_instr !== 32'h1) begin
      miscompares++;
      $display("FAIL full_head: got pc=%h instr=%h want 40000060 1", out_pc, out_instr);
    end
    tick();
    vectors++;
    if (instr_read !== 1'b0) begin
      miscompares++; $display("FAIL full_idle: got read=%b want 0", instr_read);
    end
    deq = 1'b1;
    tick();
    deq = 1'b0;
    vectors++;
    if (count !== 3'd3 || instr_read !== 1'b1 || instr_mem_address !== 32'h40000070) begin
      miscompares++;
      $display("FAIL full_resume: got count=%0d read=%b addr=%h want 3 1 40000070",
               count, instr_read, instr_mem_address);
    end
    vectors++;
    if (out_pc !== 32'h40000064) begin
      miscompares++; $display("FAIL full_head2: got %h want 40000064", out_pc);
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    tick();
    instr_mem_resp = 1'b1; instr_mem_rdata = 32'h12345678;
    tick();
    instr_mem_resp = 1'b0;
    ld_br = 1'b1; br_target = 32'h40000100;
    tick();
    ld_br = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || instr_read !== 1'b1
        || instr_mem_address !== 32'h40000064) begin
      miscompares++;
      $display("FAIL redir_flush: got count=%0d v=%b read=%b addr=%h want 0 0 1 40000064",
               count, out_valid, instr_read, instr_mem_address);
    end
    tick();
    vectors++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000064) begin
      miscompares++;
      $display("FAIL redir_hold: got read=%b addr=%h", instr_read, instr_mem_address);
    end
    instr_mem_resp = 1'b1; instr_mem_rdata = 32'hdeadbeef;
    tick();
    instr_mem_resp = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || instr_read !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_drop: got count=%0d v=%b read=%b want 0 0 0",
               count, out_valid, instr_read);
    end
    tick();
    vectors++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000100) begin
      miscompares++;
      $display("FAIL redir_target: got read=%b addr=%h want 1 40000100",
               instr_read, instr_mem_address);
    end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    tick();
    instr_mem_resp = 1'b1; instr_mem_rdata = 32'h11111111;
    ld_br = 1'b1; br_target = 32'h40000200;
    tick();
    instr_mem_resp = 1'b0; ld_br = 1'b0;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || instr_read !== 1'b0) begin
      miscompares++;
      $display("FAIL brresp_drop: got count=%0d v=%b read=%b want 0 0 0",
               count, out_valid, instr_read);
    end
    tick();
    vectors++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000200) begin
      miscompares++;
      $display("FAIL brresp_target: got read=%b addr=%h want 1 40000200",
               instr_read, instr_mem_address);
    end
    instr_mem_resp = 1'b1; instr_mem_rdata = 32'h22222222;
    tick();
    instr_mem_resp = 1'b0;
    vectors++;
    if (count !== 3'd1 || out_pc !== 32'h40000200 || out_instr !== 32'h22222222) begin
      miscompares++;
      $display("FAIL brresp_enq: got count=%0d pc=%h instr=%h want 1 40000200 22222222",
               count, out_pc, out_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    instr_mem_resp = 1'b1; instr_mem_rdata = 32'h33333333;
    tick();
    instr_mem_resp = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_read !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL async_rst: got read=%b v=%b count=%0d want 0 0 0",
               instr_read, out_valid, count);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h40000060) begin
      miscompares++;
      $display("FAIL async_restart: got read=%b addr=%h want 1 40000060",
               instr_read, instr_mem_address);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    deq = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      instr_mem_resp = 1'b1; instr_mem_rdata = 32'h1000 + 32'(i);
      tick();
      vectors++;
      if (count !== 3'd1 || out_pc !== 32'h40000060 + 32'(4 * i)
          || out_instr !== 32'h1000 + 32'(i)) begin
        miscompares++;
        $display("FAIL b2b_%0d: got count=%0d pc=%h instr=%h want 1 %h %h", i, count, out_pc,
                 out_instr, 32'h40000060 + 32'(4 * i), 32'h1000 + 32'(i));
      end
    end
    instr_mem_resp = 1'b0;
    tick();
    deq = 1'b0;
    vectors++;
    if (count !== 3'd0 || instr_mem_address !== 32'h40000088) begin
      miscompares++;
      $display("FAIL b2b_end: got count=%0d addr=%h want 0 40000088", count, instr_mem_address);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_req();
    test_redirect_resp();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end fetch stage sitting directly upstream of the instruction register/issue path. It owns the fetch PC, runs the instruction-cache read handshake, and buffers returned instructions with their PCs in a small FIFO. The decode side drains the FIFO with a valid/dequeue handshake. A branch redirect from ROB commit (ld_br) flushes all fetched-but-unissued state and restarts fetch at the resolved target.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
RESET_PC, 32'h40000060, first fetch address after reset.

Ports:
clk  input  1  system clock; all state is rising-edge.
rst  input  1  asynchronous, active-high reset.
instr_read  output  1  I-cache read request; held high until instr_mem_resp.
instr_mem_address  output  32  I-cache read address; stable while instr_read is high.
instr_mem_rdata  input  32  I-cache read data; valid when instr_mem_resp=1.
instr_mem_resp  input  1  I-cache response strobe, one cycle.
ld_br  input  1  redirect strobe from ROB branch commit.
br_target  input  32  redirect target PC; sampled when ld_br=1.
deq  input  1  consumer takes the head entry this cycle.
out_valid  output  1  FIFO non-empty.
out_instr  output  32  instruction at the FIFO head.
out_pc  output  32  PC of the instruction at the FIFO head.
count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Registers: fetch_pc (next address to request), req_addr (address of the outstanding request), FIFO storage, head/tail pointers, count, and state in {IDLE, REQ, DROP}.
- Reset (asynchronous, takes effect immediately, including mid-request):
  - fetch_pc=RESET_PC, state=IDLE, count=0, pointers=0.
  - instr_read=0, out_valid=0, count=0.
  - out_instr, out_pc and instr_mem_address read 0.
- instr_read=1 exactly in states REQ and DROP; instr_mem_address=req_addr.
- out_valid = (count!=0). out_instr and out_pc are combinational from the head entry. deq while empty is ignored.
- IDLE:
  - ld_br=1: fetch_pc<=br_target, FIFO flushed, stay IDLE.
  - Otherwise, if the FIFO will not be full after this cycle's deq: req_addr<=fetch_pc, go to REQ. The first request appears one cycle after leaving reset.
- REQ, priority order:
  - ld_br=1 and resp=0: flush, fetch_pc<=br_target, go to DROP. The outstanding request is held, because the cache cannot abort.
  - ld_br=1 and resp=1: discard the data, flush, fetch_pc<=br_target, go to IDLE.
  - resp=1:
    - Enqueue {req_addr, instr_mem_rdata} at the tail.
    - fetch_pc<=req_addr+4, with 32-bit wraparound.
    - If the FIFO still has a free slot after this enqueue and deq, set req_addr<=req_addr+4 and stay in REQ (back-to-back requests, no bubble). Otherwise go to IDLE.
- DROP:
  - resp=1: discard the data, go to IDLE.
  - ld_br=1 (with or without resp): fetch_pc<=br_target, FIFO stays empty. Stay in DROP if resp=0; go to IDLE if resp=1.
- Flush sets count=0 and head=tail=0. Flush overrides any deq or enqueue in the same cycle.
- Pointers wrap modulo DEPTH. Simultaneous enqueue and deq leaves count unchanged.
- Overflow is impossible: a request is only issued when a slot is reserved, and at most one request is outstanding.
- Latency: response cycle N → entry visible on out_* in cycle N+1.

Test Plan:
1. Reset, cache responds one cycle after each request, deq held at 1:
   - Requests go to 0x40000060, 0x40000064, 0x40000068.
   - out_pc/out_instr return in order with the matching rdata (e.g. 0x000170b3, 0x0001f133, 0x000271b3).
2. deq=0 with DEPTH=4:
   - After 4 responses, instr_read drops, count=4, out_pc=0x40000060.
   - Pulse deq once → count=3, next request goes to 0x40000070.
3. Redirect while in REQ with no response:
   - ld_br=1, br_target=0x40000100 → count=0, instr_read stays high at the old address.
   - Response data 0xdeadbeef is discarded (never enqueued).
   - Next request goes to 0x40000100.
4. ld_br and instr_mem_resp in the same cycle:
   - Data is dropped, count=0, out_valid=0.
   - Next request goes to br_target 0x40000200.
5. Async rst asserted mid-REQ between clock edges:
   - instr_read=0, out_valid=0, count=0 immediately.
   - After release, the first request goes to 0x40000060.
6. Steady stream with deq=1 every cycle for 10 responses:
   - count never exceeds 1.
   - Pointers wrap twice with PCs strictly increasing by 4 and no lost or duplicated entries.
